// File: rtl/emif_csr_pkg.sv
// Shared definitions for the EMIF CSR responder: register map, STAT/CTRL bit
// positions, responder FSM states and the default DFH word.
package emif_csr_pkg;

    localparam logic [63:0] DFH_DEFAULT = 64'h3000_0000_1000_0009;

    localparam logic [15:0] OFF_DFH     = 16'h0000;
    localparam logic [15:0] OFF_STAT    = 16'h0008;
    localparam logic [15:0] OFF_CTRL    = 16'h0010;
    localparam logic [15:0] OFF_SCRATCH = 16'h0018;

    localparam int STAT_FAIL_LSB = 8;
    localparam int STAT_ERR_BIT  = 63;
    localparam int CTRL_CLR_BIT  = 63;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_PIPE = 2'd1,
        ST_RD_RESP = 2'd2
    } csr_state_t;

    typedef enum logic [2:0] {
        REG_DFH     = 3'd0,
        REG_STAT    = 3'd1,
        REG_CTRL    = 3'd2,
        REG_SCRATCH = 3'd3,
        REG_NONE    = 3'd4
    } reg_sel_t;

    // Decode on the 64-bit word index; byte-lane bits never reach here.
    function automatic reg_sel_t decode_reg(input logic [12:0] word_addr);
        reg_sel_t sel;
        if (word_addr == OFF_DFH[15:3])
            sel = REG_DFH;
        else if (word_addr == OFF_STAT[15:3])
            sel = REG_STAT;
        else if (word_addr == OFF_CTRL[15:3])
            sel = REG_CTRL;
        else if (word_addr == OFF_SCRATCH[15:3])
            sel = REG_SCRATCH;
        else
            sel = REG_NONE;
        return sel;
    endfunction

    function automatic logic [63:0] merge_be(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  be);
        logic [63:0] res;
        res = old_val;
        for (int b = 0; b < 8; b++) begin
            if (be[b])
                res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/emif_csr_sync.sv
// Two-flop synchroniser for the per-channel calibration status levels.
// Latency: 2 cycles. No backpressure.
module emif_csr_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/emif_csr_responder.sv
// Avalon-MM CSR slave for the EMIF block: DFH, calibration status, reset control, scratch.
// Latency: readdatavalid sampled 2 edges after the accept edge; writes take effect at the accept edge.
// Backpressure: waitrequest held high for the two cycles of a read; writes never stall in IDLE.
module emif_csr_responder
    import emif_csr_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE = DFH_DEFAULT,
    parameter int          NUM_CH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       avmm_address,
    input  logic              avmm_read,
    input  logic              avmm_write,
    input  logic [63:0]       avmm_writedata,
    input  logic [7:0]        avmm_byteenable,
    output logic              avmm_waitrequest,
    output logic [63:0]       avmm_readdata,
    output logic              avmm_readdatavalid,
    input  logic [NUM_CH-1:0] cal_success,
    input  logic [NUM_CH-1:0] cal_fail,
    output logic [NUM_CH-1:0] ch_reset_req
);

    csr_state_t        state;
    reg_sel_t          rd_sel_q;
    reg_sel_t          req_sel;

    logic [NUM_CH-1:0] cal_ok_s;
    logic [NUM_CH-1:0] cal_fail_s;
    logic [NUM_CH-1:0] fail_sticky;
    logic              proto_err;
    logic              clr_pend;
    logic [NUM_CH-1:0] ctrl_q;
    logic [63:0]       scratch_q;

    logic              in_idle;
    logic              wr_accept;
    logic              rd_accept;
    logic              collision;
    logic              clr_req;
    logic [NUM_CH-1:0] ctrl_next;
    logic [63:0]       stat_word;
    logic [63:0]       ctrl_word;
    logic [63:0]       rd_mux;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^avmm_address[2:0];

    emif_csr_sync #(.WIDTH(NUM_CH)) u_sync_ok (
        .clk (clk),
        .rst (rst),
        .d   (cal_success),
        .q   (cal_ok_s)
    );

    emif_csr_sync #(.WIDTH(NUM_CH)) u_sync_fail (
        .clk (clk),
        .rst (rst),
        .d   (cal_fail),
        .q   (cal_fail_s)
    );

    assign in_idle   = (state == ST_IDLE);
    assign req_sel   = decode_reg(avmm_address[15:3]);
    assign wr_accept = in_idle && avmm_write;
    assign rd_accept = in_idle && avmm_read && !avmm_write;
    assign collision = in_idle && avmm_read && avmm_write;
    assign clr_req   = wr_accept && (req_sel == REG_CTRL) &&
                       avmm_byteenable[7] && avmm_writedata[CTRL_CLR_BIT];

    // NUM_CH never exceeds 8, so all stored CTRL bits live in byte lane 0.
    assign ctrl_next = avmm_byteenable[0] ? avmm_writedata[NUM_CH-1:0] : ctrl_q;

    always_comb begin
        stat_word                              = '0;
        stat_word[NUM_CH-1:0]                  = cal_ok_s;
        stat_word[STAT_FAIL_LSB +: NUM_CH]     = fail_sticky;
        stat_word[STAT_ERR_BIT]                = proto_err;
        ctrl_word                              = '0;
        ctrl_word[NUM_CH-1:0]                  = ctrl_q;
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel_q)
            REG_DFH:     rd_mux = DFH_VALUE;
            REG_STAT:    rd_mux = stat_word;
            REG_CTRL:    rd_mux = ctrl_word;
            REG_SCRATCH: rd_mux = scratch_q;
            default:     rd_mux = '0;
        endcase
    end

    // Register file; the sticky clear lands one cycle after the CTRL write, and a
    // coincident set still wins because it is ORed in after the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= '0;
            scratch_q   <= '0;
            fail_sticky <= '0;
            proto_err   <= 1'b0;
            clr_pend    <= 1'b0;
        end else begin
            clr_pend    <= clr_req;
            fail_sticky <= (clr_pend ? '0 : fail_sticky) | cal_fail_s;
            proto_err   <= (clr_pend ? 1'b0 : proto_err) | collision;
            if (wr_accept && (req_sel == REG_CTRL))
                ctrl_q <= ctrl_next;
            if (wr_accept && (req_sel == REG_SCRATCH))
                scratch_q <= merge_be(scratch_q, avmm_writedata, avmm_byteenable);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            rd_sel_q           <= REG_NONE;
            avmm_waitrequest   <= 1'b0;
            avmm_readdatavalid <= 1'b0;
            avmm_readdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_accept) begin
                        rd_sel_q         <= req_sel;
                        avmm_waitrequest <= 1'b1;
                        state            <= ST_RD_PIPE;
                    end
                end
                ST_RD_PIPE: begin
                    avmm_readdata      <= rd_mux;
                    avmm_readdatavalid <= 1'b1;
                    state              <= ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    avmm_readdata      <= '0;
                    avmm_readdatavalid <= 1'b0;
                    avmm_waitrequest   <= 1'b0;
                    state              <= ST_IDLE;
                end
                default: begin
                    avmm_readdata      <= '0;
                    avmm_readdatavalid <= 1'b0;
                    avmm_waitrequest   <= 1'b0;
                    state              <= ST_IDLE;
                end
            endcase
        end
    end

    assign ch_reset_req = ctrl_q;

endmodule

// File: tb/tb_emif_csr_responder.sv
// Directed and randomized bench for emif_csr_responder against a register-map model.
module tb_emif_csr_responder;

    localparam int NCH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     avmm_address;
    logic            avmm_read;
    logic            avmm_write;
    logic [63:0]     avmm_writedata;
    logic [7:0]      avmm_byteenable;
    logic            avmm_waitrequest;
    logic [63:0]     avmm_readdata;
    logic            avmm_readdatavalid;
    logic [NCH-1:0]  cal_success;
    logic [NCH-1:0]  cal_fail;
    logic [NCH-1:0]  ch_reset_req;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what software would expect to read back.
    logic [63:0]    m_scratch;
    logic [NCH-1:0] m_ctrl;
    logic [NCH-1:0] m_ok;
    logic [NCH-1:0] m_fail;
    logic           m_err;

    emif_csr_responder #(
        .DFH_VALUE (64'h3000000010000009),
        .NUM_CH    (NCH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .avmm_address       (avmm_address),
        .avmm_read          (avmm_read),
        .avmm_write         (avmm_write),
        .avmm_writedata     (avmm_writedata),
        .avmm_byteenable    (avmm_byteenable),
        .avmm_waitrequest   (avmm_waitrequest),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid),
        .cal_success        (cal_success),
        .cal_fail           (cal_fail),
        .ch_reset_req       (ch_reset_req)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [15:0] a);
        logic [63:0] r;
        r = 64'h0;
        case (a >> 3)
            16'd0: r = 64'h3000000010000009;
            16'd1: begin
                r[NCH-1:0]  = m_ok;
                r[8 +: NCH] = m_fail;
                r[63]       = m_err;
            end
            16'd2: r[NCH-1:0] = m_ctrl;
            16'd3: r = m_scratch;
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] byte_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                               input logic [7:0] be);
        logic [63:0] mask;
        mask = 64'h0;
        for (int b = 0; b < 8; b++)
            if (be[b]) mask = mask | (64'hFF << (8 * b));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] t;
        if ((a >> 3) == 16'd2) begin
            t = byte_merge({{(64-NCH){1'b0}}, m_ctrl}, d, be);
            m_ctrl = t[NCH-1:0];
            if (be[7] && d[63]) begin
                m_fail = '0;
                m_err  = 1'b0;
            end
        end else if ((a >> 3) == 16'd3) begin
            m_scratch = byte_merge(m_scratch, d, be);
        end
    endtask

    task automatic model_reset();
        m_scratch = 64'h0;
        m_ctrl    = '0;
        m_fail    = '0;
        m_err     = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        avmm_address    = a;
        avmm_writedata  = d;
        avmm_byteenable = be;
        avmm_write      = 1'b1;
        tick();
        avmm_write      = 1'b0;
        model_write(a, d, be);
    endtask

    // n counts edges after the accept edge until readdatavalid is visible; the
    // master samples it one edge later, hence latency = n + 1.
    task automatic do_read(input string tag, input logic [15:0] a, input logic [63:0] exp);
        int n;
        avmm_address = a;
        avmm_read    = 1'b1;
        check({tag, "/waitreq_idle"}, {63'h0, avmm_waitrequest}, 64'h0);
        tick();
        avmm_read = 1'b0;
        n = 0;
        while (!avmm_readdatavalid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "/latency"}, 64'(n + 1), 64'd2);
        check({tag, "/data"}, avmm_readdata, exp);
        tick();
        check({tag, "/rdv_drop"}, {63'h0, avmm_readdatavalid}, 64'h0);
        check({tag, "/data_zero"}, avmm_readdata, 64'h0);
    endtask

    initial begin
        logic [15:0] a;
        logic [63:0] d;
        logic [7:0]  be;
        int          cnt;

        rst = 1'b1;
        avmm_address = '0; avmm_read = 1'b0; avmm_write = 1'b0;
        avmm_writedata = '0; avmm_byteenable = '0;
        cal_success = '0; cal_fail = '0;
        model_reset();
        m_ok = '0;
        tick(); tick(); tick();
        check("rst/waitreq", {63'h0, avmm_waitrequest}, 64'h0);
        check("rst/rdv", {63'h0, avmm_readdatavalid}, 64'h0);
        check("rst/readdata", avmm_readdata, 64'h0);
        check("rst/ch_reset", {60'h0, ch_reset_req}, 64'h0);
        rst = 1'b0;
        tick();

        do_read("dfh", 16'h0000, 64'h3000000010000009);

        do_write(16'h0018, 64'hDEADBEEF_CAFEF00D, 8'h0F);
        do_read("scratch_be", 16'h0018, 64'h00000000_CAFEF00D);
        do_write(16'h0018, 64'h1111_2222_3333_4444, 8'h00);
        do_read("scratch_be0", 16'h0018, 64'h00000000_CAFEF00D);

        cal_success = 4'hF;
        m_ok = 4'hF;
        tick(); tick(); tick();
        cal_fail = 4'h2;
        tick();
        cal_fail = 4'h0;
        m_fail = 4'h2;
        tick(); tick(); tick();
        do_read("stat_fail", 16'h0008, 64'h0000_0000_0000_020F);
        do_write(16'h0010, 64'h8000_0000_0000_0000, 8'hFF);
        do_read("stat_clr", 16'h0008, 64'h0000_0000_0000_000F);
        do_read("ctrl_bit63", 16'h0010, 64'h0);

        do_write(16'h0010, 64'h5, 8'hFF);
        check("ctrl/ch_reset", {60'h0, ch_reset_req}, 64'h5);
        do_read("ctrl", 16'h0013, 64'h5);

        avmm_address = 16'h0018; avmm_writedata = 64'h1; avmm_byteenable = 8'hFF;
        avmm_read = 1'b1; avmm_write = 1'b1;
        tick();
        avmm_read = 1'b0; avmm_write = 1'b0;
        m_scratch = 64'h1;
        m_err = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (avmm_readdatavalid) cnt++;
            tick();
        end
        check("collide/no_rdv", 64'(cnt), 64'd0);
        do_read("collide/scratch", 16'h0018, 64'h1);
        do_read("collide/stat", 16'h0008, 64'h8000_0000_0000_000F);

        // Held read: three accepts in nine edges, one every third cycle.
        avmm_address = 16'h0000;
        avmm_read = 1'b1;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (avmm_readdatavalid) cnt++;
        end
        avmm_read = 1'b0;
        check("b2b/rdv_count", 64'(cnt), 64'd3);
        tick(); tick(); tick();

        avmm_address = 16'h0000;
        avmm_read = 1'b1;
        tick();
        avmm_read = 1'b0;
        check("abort/in_pipe", {63'h0, avmm_waitrequest}, 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (avmm_readdatavalid) cnt++;
            tick();
        end
        check("abort/no_rdv", 64'(cnt), 64'd0);
        check("abort/ch_reset", {60'h0, ch_reset_req}, 64'h0);
        do_read("unmapped", 16'h0040, 64'h0);
        do_read("abort/scratch", 16'h0018, 64'h0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 16'h0000;
                1: a = 16'h0008;
                2: a = 16'h0010;
                3: a = 16'h0018;
                4: a = 16'h0020 + 16'($urandom_range(0, 200) << 3);
                default: a = 16'($urandom);
            endcase
            a[2:0] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d  = {$urandom, $urandom};
                be = 8'($urandom);
                do_write(a, d, be);
                check("rnd/ch_reset", {60'h0, ch_reset_req}, {60'h0, m_ctrl});
            end else begin
                do_read("rnd/read", a, model_read(a));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/emif_csr_responder.md
EMIF_CSR_RESPONDER -- requirements
Module: emif_csr_responder

Interface
REQ-001 SHALL have parameter DFH_VALUE, default 64'h3000000010000009, DFH word returned at offset 0x00.
REQ-002 SHALL have parameter NUM_CH, default 4, range 1..8, number of EMIF channels reported and controlled.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port avmm_address, input, 16: byte offset within the EMIF CSR region; bits [2:0] ignored.
REQ-006 SHALL have ports avmm_read and avmm_write, input, 1 each: request strobes.
REQ-007 SHALL have port avmm_writedata, input, 64: write data.
REQ-008 SHALL have port avmm_byteenable, input, 8: per-byte write enable.
REQ-009 SHALL have port avmm_waitrequest, output, 1: request not accepted this cycle.
REQ-010 SHALL have port avmm_readdata, output, 64: read data.
REQ-011 SHALL have port avmm_readdatavalid, output, 1: readdata valid.
REQ-012 SHALL have port cal_success, input, NUM_CH: per-channel calibration pass, level.
REQ-013 SHALL have port cal_fail, input, NUM_CH: per-channel calibration fail, level.
REQ-014 SHALL have port ch_reset_req, output, NUM_CH: per-channel EMIF reset request.

Function
REQ-015 Register map: 0x00 DFH (RO); 0x08 STAT (RO); 0x10 CTRL (RW); 0x18 SCRATCH (RW); all other offsets read 64'h0, writes dropped.
REQ-016 STAT[NUM_CH-1:0] = cal_success after 2-flop synchroniser; STAT[8+:NUM_CH] = sticky cal_fail (set by synchronised input, cleared only by CTRL[63] or rst); STAT[63] = sticky protocol error; other bits 0.
REQ-017 CTRL[NUM_CH-1:0] drive ch_reset_req directly from the register; CTRL[63] is self-clearing: reads 0, a write of 1 clears STAT sticky bits on the next cycle.
REQ-018 Writes honour byteenable per byte for CTRL and SCRATCH; byteenable 8'h00 is a legal no-op write.
REQ-019 FSM states IDLE, RD_PIPE, RD_RESP.
REQ-020 IDLE: waitrequest=0; accepted read -> RD_PIPE; accepted write updates the register at the clock edge, stays in IDLE.
REQ-021 RD_PIPE: waitrequest=1; register captured -> RD_RESP.
REQ-022 RD_RESP: waitrequest=1; readdatavalid=1 for exactly one cycle -> IDLE.
REQ-023 Read latency fixed at 2 cycles from accept edge to readdatavalid; back-to-back reads accepted every 3 cycles.
REQ-024 read and write asserted together in IDLE: write performed, read dropped, STAT[63] set.
REQ-025 Sticky-fail set and CTRL[63] clear in the same cycle: set wins.
REQ-026 readdata SHALL be 64'h0 whenever readdatavalid=0.

Reset
REQ-027 rst SHALL force: FSM IDLE, waitrequest 0, readdatavalid 0, readdata 0, CTRL 0 (ch_reset_req 0), SCRATCH 0, sticky bits 0, synchronisers 0.
REQ-028 rst asserted mid-read SHALL abort the read; no readdatavalid is issued after rst deasserts.

Structure
REQ-029 Shared package emif_csr_pkg SHALL hold register offsets, bit positions, state enum and the DFH default.
REQ-030 One sub-module, emif_csr_sync, SHALL implement the NUM_CH-wide 2-flop synchroniser.

Verification
REQ-031 Read 0x00 after reset -> readdatavalid 2 cycles after accept, data 64'h3000000010000009.
REQ-032 Write 0x18 = 64'hDEADBEEF_CAFEF00D, be 8'h0F, then read -> 64'h00000000_CAFEF00D.
REQ-033 cal_success=4'hF, cal_fail pulses 4'h2 for one cycle, read 0x08 after 3 cycles -> 64'h0000_0000_0000_020F; write CTRL[63]=1, read -> 64'h0000_0000_0000_000F.
REQ-034 Write 0x10 = 64'h5 -> ch_reset_req=4'h5 next cycle; read 0x10 -> 64'h5.
REQ-035 read and write together to 0x18 with data 64'h1 -> SCRATCH=1, no readdatavalid, STAT[63]=1.
REQ-036 rst asserted in RD_PIPE -> no readdatavalid; read 0x40 afterwards -> 64'h0.
